// File: rtl/sparc_fetch_unit.sv
// SPARC8 fetch stage: owns PC/nPC, drives the ROM address and registers the IF/ID contents.
// One-cycle latency from ROM address to IFID_*; Stall freezes PC, nPC, IF/ID and the fetch counter.
module sparc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0100_0000,
  parameter int          ADDR_W    = 9,
  parameter int          CNT_W     = 16
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              Stall,
  input  logic              Branch_Taken,
  input  logic [31:0]       Branch_Target,
  input  logic              Annul,
  output logic [ADDR_W-1:0] Imem_Addr,
  input  logic [31:0]       Imem_Data,
  output logic [31:0]       IFID_Instr,
  output logic [31:0]       IFID_PC,
  output logic              IFID_Valid,
  output logic [31:0]       PC_Out,
  output logic [31:0]       nPC_Out,
  output logic              Align_Err,
  output logic [CNT_W-1:0]  Fetch_Count
);

  typedef enum logic {BOOT, RUN} state_t;
  state_t state;

  logic pc_misaligned;
  logic tgt_misaligned;
  logic squash;

  assign Imem_Addr      = PC_Out[ADDR_W-1:0];
  assign pc_misaligned  = (PC_Out[1:0] != 2'b00);
  assign tgt_misaligned = Branch_Taken && (Branch_Target[1:0] != 2'b00);
  assign squash         = Annul || pc_misaligned;

  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr) begin
      state       <= BOOT;
      PC_Out      <= RESET_PC;
      nPC_Out     <= RESET_PC + 32'd4;
      IFID_Instr  <= NOP_INSTR;
      IFID_PC     <= 32'd0;
      IFID_Valid  <= 1'b0;
      Align_Err   <= 1'b0;
      Fetch_Count <= '0;
    end else begin
      case (state)
        BOOT: begin
          IFID_Instr <= NOP_INSTR;
          IFID_Valid <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          if (!Stall) begin
            IFID_PC <= PC_Out;
            if (squash) begin
              IFID_Instr <= NOP_INSTR;
              IFID_Valid <= 1'b0;
            end else begin
              IFID_Instr <= Imem_Data;
              IFID_Valid <= 1'b1;
              if (Fetch_Count != {CNT_W{1'b1}})
                Fetch_Count <= Fetch_Count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            // The word fetched alongside a taken branch is its delay slot.
            if (Branch_Taken) begin
              PC_Out  <= Branch_Target;
              nPC_Out <= Branch_Target + 32'd4;
            end else begin
              PC_Out  <= nPC_Out;
              nPC_Out <= nPC_Out + 32'd4;
            end
            if (pc_misaligned || tgt_misaligned)
              Align_Err <= 1'b1;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_sparc_fetch_unit.sv
// Bench for sparc_fetch_unit: directed scenarios plus randomized run against a reference model.
module tb_sparc_fetch_unit;

  localparam logic [31:0] NOP = 32'h0100_0000;

  logic        Clk = 1'b0;
  logic        Clr = 1'b1;
  logic        Stall = 1'b0;
  logic        Branch_Taken = 1'b0;
  logic [31:0] Branch_Target = 32'd0;
  logic        Annul = 1'b0;
  logic [8:0]  Imem_Addr;
  logic [31:0] Imem_Data;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PC;
  logic        IFID_Valid;
  logic [31:0] PC_Out;
  logic [31:0] nPC_Out;
  logic        Align_Err;
  logic [15:0] Fetch_Count;

  logic [31:0] rom [0:127];
  assign Imem_Data = rom[Imem_Addr[8:2]];

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit          m_boot;
  logic [31:0] m_pc, m_npc, m_instr, m_ifpc;
  bit          m_valid, m_err;
  int          m_cnt;

  sparc_fetch_unit dut (
    .Clk(Clk), .Clr(Clr), .Stall(Stall), .Branch_Taken(Branch_Taken),
    .Branch_Target(Branch_Target), .Annul(Annul), .Imem_Addr(Imem_Addr),
    .Imem_Data(Imem_Data), .IFID_Instr(IFID_Instr), .IFID_PC(IFID_PC),
    .IFID_Valid(IFID_Valid), .PC_Out(PC_Out), .nPC_Out(nPC_Out),
    .Align_Err(Align_Err), .Fetch_Count(Fetch_Count)
  );

  always #5 Clk = ~Clk;

  task automatic model_reset();
    m_boot = 1; m_pc = 32'd0; m_npc = 32'd4; m_instr = NOP; m_ifpc = 32'd0;
    m_valid = 0; m_err = 0; m_cnt = 0;
  endtask

  // Advance the model by one clock using current inputs, then clock the DUT.
  task automatic tick();
    logic [31:0] word;
    word = rom[m_pc[8:2]];
    if (m_boot) begin
      m_instr = NOP; m_valid = 0; m_boot = 0;
    end else if (!Stall) begin
      m_ifpc = m_pc;
      if (Annul || (m_pc % 4) != 0) begin
        m_instr = NOP; m_valid = 0;
      end else begin
        m_instr = word; m_valid = 1;
        if (m_cnt < 65535) m_cnt = m_cnt + 1;
      end
      if ((m_pc % 4) != 0 || (Branch_Taken && (Branch_Target % 4) != 0)) m_err = 1;
      if (Branch_Taken) begin
        m_pc = Branch_Target; m_npc = Branch_Target + 32'd4;
      end else begin
        m_pc = m_npc; m_npc = m_npc + 32'd4;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    Clr = 1;
    repeat (3) @(posedge Clk);
    #1;
    model_reset();
    checks++; if (PC_Out !== 32'd0) begin errors++; $display("FAIL reset_pc got %h want 0", PC_Out); end
    checks++; if (nPC_Out !== 32'd4) begin errors++; $display("FAIL reset_npc got %h want 4", nPC_Out); end
    checks++; if (IFID_Instr !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", IFID_Instr, NOP); end
    checks++; if (IFID_Valid !== 1'b0 || IFID_PC !== 32'd0) begin errors++; $display("FAIL reset_ifid got v=%b pc=%h want v=0 pc=0", IFID_Valid, IFID_PC); end
    checks++; if (Fetch_Count !== 16'd0 || Align_Err !== 1'b0) begin errors++; $display("FAIL reset_cnt_err got %0d/%b want 0/0", Fetch_Count, Align_Err); end
    Clr = 0;
    tick();
    checks++; if (IFID_Valid !== 1'b0 || PC_Out !== 32'd0) begin errors++; $display("FAIL boot got v=%b pc=%h want v=0 pc=0", IFID_Valid, PC_Out); end
    tick();
    checks++; if (IFID_Instr !== 32'hA000_0001 || IFID_PC !== 32'd0 || IFID_Valid !== 1'b1) begin errors++; $display("FAIL fetch_a got %h@%h v=%b want a0000001@0 v=1", IFID_Instr, IFID_PC, IFID_Valid); end
    tick();
    checks++; if (IFID_Instr !== 32'hB000_0002 || IFID_PC !== 32'd4 || IFID_Valid !== 1'b1) begin errors++; $display("FAIL fetch_b got %h@%h v=%b want b0000002@4 v=1", IFID_Instr, IFID_PC, IFID_Valid); end
  endtask

  task automatic test_stall();
    Stall = 1;
    repeat (2) begin
      tick();
      checks++; if (IFID_Instr !== 32'hB000_0002 || IFID_PC !== 32'd4 || PC_Out !== 32'd8 || Fetch_Count !== 16'd2) begin
        errors++; $display("FAIL stall_hold got %h@%h pc=%h cnt=%0d want b0000002@4 pc=8 cnt=2", IFID_Instr, IFID_PC, PC_Out, Fetch_Count); end
    end
    Stall = 0;
    tick();
    checks++; if (IFID_Instr !== 32'hC000_0003 || IFID_PC !== 32'd8 || Fetch_Count !== 16'd3 || nPC_Out !== 32'd16) begin
      errors++; $display("FAIL stall_release got %h@%h cnt=%0d npc=%h want c0000003@8 cnt=3 npc=10", IFID_Instr, IFID_PC, Fetch_Count, nPC_Out); end
  endtask

  task automatic test_branch();
    Branch_Taken = 1; Branch_Target = 32'h40;
    tick();
    Branch_Taken = 0;
    checks++; if (IFID_Instr !== 32'hD000_0004 || IFID_PC !== 32'h0C || IFID_Valid !== 1'b1) begin
      errors++; $display("FAIL delay_slot got %h@%h v=%b want d0000004@c v=1", IFID_Instr, IFID_PC, IFID_Valid); end
    checks++; if (PC_Out !== 32'h40 || nPC_Out !== 32'h44) begin errors++; $display("FAIL branch_pc got %h/%h want 40/44", PC_Out, nPC_Out); end
    tick();
    checks++; if (IFID_PC !== 32'h40 || IFID_Instr !== rom[16] || Fetch_Count !== 16'd5) begin
      errors++; $display("FAIL branch_target_fetch got %h@%h cnt=%0d want %h@40 cnt=5", IFID_Instr, IFID_PC, Fetch_Count, rom[16]); end
  endtask

  task automatic test_annul();
    Branch_Taken = 1; Branch_Target = 32'h40; Annul = 1;
    tick();
    Branch_Taken = 0; Annul = 0;
    checks++; if (IFID_Instr !== NOP || IFID_Valid !== 1'b0 || Fetch_Count !== 16'd5) begin
      errors++; $display("FAIL annul got %h v=%b cnt=%0d want 01000000 v=0 cnt=5", IFID_Instr, IFID_Valid, Fetch_Count); end
    tick();
    checks++; if (IFID_PC !== 32'h40 || IFID_Valid !== 1'b1 || Fetch_Count !== 16'd6) begin
      errors++; $display("FAIL annul_next got pc=%h v=%b cnt=%0d want 40 1 6", IFID_PC, IFID_Valid, Fetch_Count); end
  endtask

  task automatic test_misaligned();
    Branch_Taken = 1; Branch_Target = 32'h42;
    tick();
    Branch_Taken = 0;
    checks++; if (Align_Err !== 1'b1 || PC_Out !== 32'h42 || IFID_Valid !== 1'b1) begin
      errors++; $display("FAIL misalign_tgt got err=%b pc=%h v=%b want 1 42 1", Align_Err, PC_Out, IFID_Valid); end
    Branch_Taken = 1; Branch_Target = 32'h40;
    tick();
    Branch_Taken = 0;
    checks++; if (IFID_Valid !== 1'b0 || IFID_Instr !== NOP || IFID_PC !== 32'h42) begin
      errors++; $display("FAIL misalign_squash got %h@%h v=%b want 01000000@42 v=0", IFID_Instr, IFID_PC, IFID_Valid); end
    tick();
    checks++; if (Align_Err !== 1'b1 || IFID_Valid !== 1'b1 || IFID_PC !== 32'h40) begin
      errors++; $display("FAIL misalign_sticky got err=%b v=%b pc=%h want 1 1 40", Align_Err, IFID_Valid, IFID_PC); end
  endtask

  task automatic test_async_reset();
    Branch_Taken = 1; Branch_Target = 32'h40;
    tick();
    Branch_Taken = 0; Stall = 1;
    tick();
    checks++; if (PC_Out !== 32'h40) begin errors++; $display("FAIL pre_reset_pc got %h want 40", PC_Out); end
    #1 Clr = 1;
    #1;
    checks++; if (PC_Out !== 32'd0 || nPC_Out !== 32'd4 || IFID_Valid !== 1'b0 || Fetch_Count !== 16'd0 || Align_Err !== 1'b0) begin
      errors++; $display("FAIL async_reset got pc=%h npc=%h v=%b cnt=%0d err=%b want 0 4 0 0 0", PC_Out, nPC_Out, IFID_Valid, Fetch_Count, Align_Err); end
    Clr = 0;
    model_reset();
    Branch_Taken = 1; Branch_Target = 32'h80; Annul = 1;
    tick();
    Branch_Taken = 0; Annul = 0;
    checks++; if (IFID_Valid !== 1'b0 || PC_Out !== 32'd0) begin errors++; $display("FAIL reboot got v=%b pc=%h want 0 0", IFID_Valid, PC_Out); end
    Stall = 0;
    tick();
    checks++; if (IFID_Instr !== 32'hA000_0001 || IFID_PC !== 32'd0 || Fetch_Count !== 16'd1) begin
      errors++; $display("FAIL reboot_fetch got %h@%h cnt=%0d want a0000001@0 1", IFID_Instr, IFID_PC, Fetch_Count); end
  endtask

  task automatic test_wrap();
    Branch_Taken = 1; Branch_Target = 32'hFFFF_FFFC;
    tick();
    Branch_Taken = 0;
    checks++; if (PC_Out !== 32'hFFFF_FFFC || nPC_Out !== 32'd0) begin errors++; $display("FAIL wrap_tgt got %h/%h want fffffffc/0", PC_Out, nPC_Out); end
    tick();
    checks++; if (PC_Out !== 32'd0 || nPC_Out !== 32'd4 || IFID_Instr !== rom[127] || IFID_PC !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_next got pc=%h npc=%h %h@%h want 0 4 %h@fffffffc", PC_Out, nPC_Out, IFID_Instr, IFID_PC, rom[127]); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      Stall         = ($urandom_range(0, 3) == 0);
      Branch_Taken  = ($urandom_range(0, 4) == 0);
      Annul         = ($urandom_range(0, 5) == 0);
      Branch_Target = ($urandom_range(0, 9) == 0) ? $urandom : ($urandom & 32'h0000_01FC);
      tick();
      checks++; if (PC_Out !== m_pc || nPC_Out !== m_npc) begin errors++; $display("FAIL rand_pc[%0d] got %h/%h want %h/%h", i, PC_Out, nPC_Out, m_pc, m_npc); end
      checks++; if (IFID_Instr !== m_instr || IFID_PC !== m_ifpc || IFID_Valid !== m_valid) begin
        errors++; $display("FAIL rand_ifid[%0d] got %h@%h v=%b want %h@%h v=%b", i, IFID_Instr, IFID_PC, IFID_Valid, m_instr, m_ifpc, m_valid); end
      checks++; if (Fetch_Count !== m_cnt[15:0] || Align_Err !== m_err) begin
        errors++; $display("FAIL rand_cnt_err[%0d] got %0d/%b want %0d/%b", i, Fetch_Count, Align_Err, m_cnt, m_err); end
    end
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = $urandom;
    rom[0] = 32'hA000_0001; rom[1] = 32'hB000_0002; rom[2] = 32'hC000_0003; rom[3] = 32'hD000_0004;
    model_reset();
    test_reset();
    test_stall();
    test_branch();
    test_annul();
    test_misaligned();
    test_async_reset();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
